// File: rtl/write_bank.sv
// Single-bank open-page DRAM write model: a request is classified as a row hit,
// a closed-bank miss or a row conflict, then walks PRE/ACT/WR before committing.
module write_bank #(
    parameter int ROW_W  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ROW_W-1:0]  row_num,
    input  logic [DATA_W-1:0] data_in,
    input  logic              input_valid,
    input  logic              close_valid,
    output logic              ready,
    output logic              write_done,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam int ROWS = 2 ** ROW_W;

    typedef enum logic [1:0] {IDLE, PRE, ACT, WR} state_t;

    state_t            state;
    logic [ROW_W-1:0]  open_row;
    logic              open_vld;
    logic [ROW_W-1:0]  req_row;
    logic [DATA_W-1:0] req_data;
    logic              req_pend;
    logic [DATA_W-1:0] bank [ROWS];

    logic accept;
    logic hit;
    logic conflict;

    assign ready    = (state == IDLE);
    assign rd_data  = bank[rd_row];
    assign accept   = ready && input_valid;
    assign hit      = accept && open_vld && (open_row == row_num);
    assign conflict = accept && open_vld && (open_row != row_num);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            open_row     <= '0;
            open_vld     <= 1'b0;
            req_row      <= '0;
            req_data     <= '0;
            req_pend     <= 1'b0;
            write_done   <= 1'b0;
            hit_cnt      <= '0;
            conflict_cnt <= '0;
            for (int i = 0; i < ROWS; i++) bank[i] <= DATA_W'(i);
        end else begin
            write_done <= 1'b0;
            if (hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (conflict && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    // A write always takes priority over an explicit precharge.
                    if (input_valid) begin
                        req_row  <= row_num;
                        req_data <= data_in;
                        req_pend <= 1'b1;
                        if (!open_vld)
                            state <= ACT;
                        else if (open_row == row_num)
                            state <= WR;
                        else
                            state <= PRE;
                    end else if (close_valid && open_vld) begin
                        req_pend <= 1'b0;
                        state    <= PRE;
                    end
                end
                PRE: begin
                    open_vld <= 1'b0;
                    state    <= req_pend ? ACT : IDLE;
                end
                ACT: begin
                    open_row <= req_row;
                    open_vld <= 1'b1;
                    state    <= WR;
                end
                WR: begin
                    // Row is left open afterwards (open-page policy).
                    bank[req_row] <= req_data;
                    write_done    <= 1'b1;
                    req_pend      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_write_bank.sv
// Randomized bench for write_bank: a latency-level reference model is compared
// against the DUT every cycle, with literal expectations from the test plan.
module tb_write_bank;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  row_num;
    logic [31:0] data_in;
    logic        input_valid;
    logic        close_valid;
    logic        ready;
    logic        write_done;
    logic [3:0]  rd_row;
    logic [31:0] rd_data;
    logic [7:0]  hit_cnt;
    logic [7:0]  conflict_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    bit         rd_rand = 1'b1;
    logic [3:0] rd_fix  = '0;
    logic [3:0] rd_r    = '0;
    assign rd_row = rd_rand ? rd_r : rd_fix;

    write_bank dut (
        .clk          (clk),
        .rstn         (rstn),
        .row_num      (row_num),
        .data_in      (data_in),
        .input_valid  (input_valid),
        .close_valid  (close_valid),
        .ready        (ready),
        .write_done   (write_done),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .hit_cnt      (hit_cnt),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        rd_r = 4'($urandom);
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: each accepted request is just "commit after lat edges",
    // with lat picked from the open-row bookkeeping.
    logic [31:0] mbank [16];
    int  mopen, mhit, mconf, m_crow, m_commit, m_busy, mn, mlat, mr;
    logic [31:0] m_cdata;
    bit  m_pend, m_ready, m_done;

    initial begin
        mn = 0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int i = 0; i < 16; i++) mbank[i] = i;
                mopen = -1; mhit = 0; mconf = 0;
                m_pend = 0; m_ready = 1; m_done = 0; m_busy = mn;
            end else begin
                mn++;
                m_done = 0;
                if (m_pend && mn == m_commit) begin
                    mbank[m_crow] = m_cdata;
                    m_done = 1;
                    m_pend = 0;
                end
                if (m_ready) begin
                    if (input_valid) begin
                        mr = int'(row_num);
                        if (mopen < 0) mlat = 2;
                        else if (mopen == mr) begin
                            mlat = 1;
                            if (mhit < 255) mhit++;
                        end else begin
                            mlat = 3;
                            if (mconf < 255) mconf++;
                        end
                        mopen = mr; m_crow = mr; m_cdata = data_in;
                        m_pend = 1; m_commit = mn + mlat; m_busy = mn + mlat;
                    end else if (close_valid && mopen >= 0) begin
                        mopen = -1;
                        m_busy = mn + 1;
                    end
                end
                m_ready = (mn >= m_busy);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("ready", ready, m_ready);
            check("write_done", write_done, m_done);
            check("hit_cnt", hit_cnt, mhit);
            check("conflict_cnt", conflict_cnt, mconf);
            check("rd_data", rd_data, mbank[rd_row]);
        end
    end

    task automatic do_write(input int row, input logic [31:0] d, input bit cls,
                            input bit extra, output int lat, output int dcyc);
        int acc, k;
        lat = -1; dcyc = -1;
        row_num = 4'(row); data_in = d; input_valid = 1'b1; close_valid = cls;
        k = 0;
        while (!ready && k < 20) begin @(negedge clk); k++; end
        if (!ready) begin
            check("accept_wait", ready, 1);
            input_valid = 1'b0; close_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        input_valid = 1'b0; close_valid = 1'b0;
        row_num = 4'($urandom); data_in = $urandom;
        if (extra) begin
            @(negedge clk); input_valid = 1'b1;
            @(negedge clk); input_valid = 1'b0;
        end
        k = 0;
        do begin @(negedge clk); k++; end while (!write_done && k < 8);
        if (!write_done) check("done_wait", write_done, 1);
        else begin
            dcyc = cyc;
            lat  = dcyc - acc;
        end
    endtask

    task automatic peek(input int row, input logic [31:0] exp, input string nm);
        rd_rand = 1'b0;
        rd_fix  = 4'(row);
        #1;
        check(nm, rd_data, exp);
        rd_rand = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int lat, dc, prev, op, k;
        rstn = 1'b1; input_valid = 1'b0; close_valid = 1'b0;
        row_num = '0; data_in = '0;
        #3 rstn = 1'b0; chk_en = 1'b1;
        #20 rstn = 1'b1;
        @(negedge clk);
        check("reset_hit", hit_cnt, 0);
        check("reset_ready", ready, 1);

        // 1: closed-bank miss
        do_write(5, 32'hA5A5A5A5, 0, 0, lat, dc);
        check("t1_lat", lat, 2);
        peek(5, 32'hA5A5A5A5, "t1_rd5");
        check("t1_hit", hit_cnt, 0);
        check("t1_conf", conflict_cnt, 0);

        // 2: hit
        do_write(5, 32'h11, 0, 0, lat, dc);
        check("t2_lat", lat, 1);
        check("t2_hit", hit_cnt, 1);
        peek(5, 32'h11, "t2_rd5");
        for (int i = 0; i < 5; i++) peek(i, i, "t2_rows");

        // 3: conflict, with an ignored strobe while busy
        do_write(9, 32'h22, 0, 1, lat, dc);
        check("t3_lat", lat, 3);
        check("t3_conf", conflict_cnt, 1);
        check("t3_hit", hit_cnt, 1);
        peek(9, 32'h22, "t3_rd9");

        // 4: explicit close, then a closed miss
        close_valid = 1'b1;
        @(negedge clk);
        close_valid = 1'b0;
        check("t4_busy", ready, 0);
        @(negedge clk);
        check("t4_ready", ready, 1);
        check("t4_nodone", write_done, 0);
        do_write(9, 32'h33, 0, 0, lat, dc);
        check("t4_lat", lat, 2);
        check("t4_hit", hit_cnt, 1);

        // 5: reset while the row-3 conflict is in ACT
        row_num = 4'd3; data_in = 32'hFF; input_valid = 1'b1;
        @(posedge clk); #1 input_valid = 1'b0;
        @(posedge clk); #2 rstn = 1'b0;
        #1;
        check("t5_ready", ready, 1);
        check("t5_done", write_done, 0);
        check("t5_hit", hit_cnt, 0);
        check("t5_conf", conflict_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        check("t5_done_after", write_done, 0);
        peek(3, 3, "t5_rd3");

        // 6: saturation on a stream of hits
        do_write(0, $urandom, 0, 0, lat, dc);
        check("t6_first_lat", lat, 2);
        prev = dc;
        for (int i = 0; i < 300; i++) begin
            do_write(0, $urandom, 0, 0, lat, dc);
            check("t6_spacing", dc - prev, 2);
            prev = dc;
        end
        check("t6_hit_sat", hit_cnt, 255);
        check("t6_conf", conflict_cnt, 0);

        // Random mix of writes, closes and idle gaps
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 9);
            if (op < 6) begin
                do_write($urandom_range(0, 3), $urandom, 1'($urandom), 0, lat, dc);
            end else if (op < 8) begin
                close_valid = 1'b1;
                @(negedge clk);
                close_valid = 1'b0;
                k = 0;
                while (!ready && k < 5) begin @(negedge clk); k++; end
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/write_bank.md
Name: write_bank

Overview:
- Write-side counterpart of the single-bank row-buffer read model.
- Accepts one write request at a time (row index plus data word) and models open-row DRAM timing: row hit, closed-bank miss, or row conflict.
- Commits the word into a 16-entry bank and pulses a completion flag.
- Provides a combinational readback port and hit/conflict statistics for verification.

Parameters:
- ROW_W, 4, width of the row index; the bank has 2**ROW_W rows.
- DATA_W, 32, width of a data word.
- CNT_W, 8, width of each saturating statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- row_num  in  ROW_W  target row of a write request
- data_in  in  DATA_W  write data
- input_valid  in  1  write request strobe
- close_valid  in  1  explicit precharge request (close the open row)
- ready  out  1  combinational; high when state is IDLE; a request is accepted on a rising edge where ready && input_valid
- write_done  out  1  registered; one-cycle pulse when the write commits
- rd_row  in  ROW_W  debug readback address
- rd_data  out  DATA_W  combinational bank[rd_row]
- hit_cnt  out  CNT_W  count of accepted row-hit writes, saturating
- conflict_cnt  out  CNT_W  count of accepted row-conflict writes, saturating

Behaviour:
- Reset (rstn low, asynchronous), all of the following apply immediately:
  - state=IDLE, open_row invalid (bank closed).
  - write_done=0, hit_cnt=0, conflict_cnt=0.
  - bank[i]=i for every row i, the same preload as the read model.
  - Latched request registers cleared.
- Reset mid-operation: any in-flight write is discarded, with no bank update and no write_done pulse.
- States and transitions:
  - IDLE: on accept, latch row_num and data_in.
    - open_row valid and equal to row_num (hit) -> WR.
    - open_row invalid (closed) -> ACT.
    - open_row valid and different (conflict) -> PRE.
  - PRE: one cycle; clears the open_row valid bit.
    - -> ACT when a request is latched.
    - -> IDLE when entered via close_valid.
  - ACT: one cycle; open_row <= latched row, marked valid; -> WR.
  - WR: one cycle; bank[latched row] <= latched data; write_done <= 1 for exactly the following cycle; -> IDLE.
- Latency, with the accepting edge as E0:
  - hit: commit and write_done rise at E1.
  - closed: at E2.
  - conflict: at E3.
  - ready returns high in the cycle write_done is high, so back-to-back hits accept every 2 cycles.
- Requests while busy:
  - input_valid while ready=0 is ignored; no queueing.
  - The requester must hold input_valid until it is accepted.
- close_valid:
  - Honoured only in IDLE, only with input_valid low, and only with a valid open row: IDLE -> PRE -> IDLE.
  - Ignored when the bank is already closed.
  - When input_valid and close_valid are both high, the write wins and close_valid is dropped.
- Open-page policy: the row stays open after WR.
- Statistics:
  - Counters increment at the accepting edge.
  - Closed-bank misses count in neither counter.
  - Both counters saturate at 2**CNT_W-1 and do not wrap.
- rd_data reflects the committed write from the cycle after the WR edge.
- Inputs are sampled only at the accepting edge; changes on row_num or data_in afterwards have no effect on the in-flight write.

Test Plan:
1. Reset, then write row 5 with data 0xA5A5A5A5 -> closed miss; write_done at E2; rd_row=5 gives 0xA5A5A5A5; hit_cnt=0, conflict_cnt=0.
2. Follow with a write to row 5, data 0x11 -> hit; write_done at E1; hit_cnt=1; rd_data(5)=0x11; rows 0-4 still read 0-4.
3. Follow with a write to row 9, data 0x22 -> conflict; write_done at E3; conflict_cnt=1; ready low for cycles E0..E2; a second input_valid pulse during busy produces no extra write.
4. close_valid alone with row 9 open -> ready low for one cycle, no write_done; then write row 9 -> closed-miss latency (E2); hit_cnt unchanged.
5. Assert rstn low during ACT of a write to row 3, data 0xFF -> write_done stays 0; rd_data(3)=3; counters=0; ready high while in reset.
6. 300 consecutive hits to row 0 -> hit_cnt saturates at 255; every write_done spaced 2 cycles apart.
